// File: rtl/sdram_responder.sv
// Behavioural stand-in for a 16-bit SDRAM chip: decodes the controller's command bus,
// serves read/write bursts from an internal RAM and latches the first protocol violation.
module sdram_responder #(
  parameter int MEM_AW = 16,
  parameter int RCD    = 3
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        sdram_cke,
  input  logic        sdram_ncs,
  input  logic        sdram_nras,
  input  logic        sdram_ncas,
  input  logic        sdram_nwe,
  input  logic [1:0]  sdram_ba,
  input  logic [12:0] sdram_a,
  input  logic        sdram_dqml,
  input  logic        sdram_dqmh,
  input  logic [15:0] dq_in,
  output logic [15:0] dq_out,
  output logic        dq_oe,
  output logic        mode_ok,
  output logic        err,
  output logic [2:0]  err_code,
  output logic [15:0] refresh_cnt
);
  localparam int         RW        = MEM_AW - 11;
  localparam logic [3:0] TRCD_LOAD = 4'(RCD - 1);

  typedef enum logic {B_IDLE = 1'b0, B_OPEN = 1'b1} bank_t;

  bank_t [3:0]         r_bank, w_bank_next;
  logic  [3:0][RW-1:0] r_row, w_row_next;
  logic  [3:0][3:0]    r_trcd, w_trcd_next;

  logic        r_mode_ok, w_mode_ok_next;
  logic        r_cl3, w_cl3_next;
  logic [1:0]  r_bl, w_bl_next;
  logic        r_ilv, w_ilv_next;
  logic        r_sw, w_sw_next;

  logic          r_bst_act, w_bst_act_next;
  logic          r_bst_wr, w_bst_wr_next;
  logic          r_bst_ap, w_bst_ap_next;
  logic [1:0]    r_bst_bank, w_bst_bank_next;
  logic [RW-1:0] r_bst_row, w_bst_row_next;
  logic [8:0]    r_bst_col, w_bst_col_next;
  logic [2:0]    r_bst_k, w_bst_k_next;
  logic [2:0]    r_bst_last, w_bst_last_next;

  logic        r_v1, w_v1_next;
  logic        r_v2, w_v2_next;
  logic [15:0] r_hold, w_hold_next;
  logic [15:0] r_dq_out, w_dq_out_next;
  logic        r_dq_oe, w_dq_oe_next;
  logic        r_err, w_err_next;
  logic [2:0]  r_err_code, w_err_code_next;
  logic [15:0] r_ref_cnt, w_ref_cnt_next;

  logic          w_iss_valid, w_iss_wr;
  logic [1:0]    w_iss_bank;
  logic [RW-1:0] w_iss_row;
  logic [8:0]    w_iss_col;
  logic [MEM_AW-1:0] w_addr;
  logic          w_err_hit;
  logic [2:0]    w_err_val;
  logic [2:0]    w_new_last;

  logic [7:0]  r_mem_lo [2**MEM_AW];
  logic [7:0]  r_mem_hi [2**MEM_AW];
  logic [15:0] r_ram_q;

  logic [3:0] w_cmd;
  logic w_act, w_rd, w_wr, w_bt, w_pre, w_ref, w_lmr;
  logic w_gated, w_any_open, w_rw_ok, w_trunc, w_unused;

  assign w_cmd = {sdram_ncs, sdram_nras, sdram_ncas, sdram_nwe};
  assign w_act = sdram_cke && (w_cmd == 4'b0011);
  assign w_rd  = sdram_cke && (w_cmd == 4'b0101);
  assign w_wr  = sdram_cke && (w_cmd == 4'b0100);
  assign w_bt  = sdram_cke && (w_cmd == 4'b0110);
  assign w_pre = sdram_cke && (w_cmd == 4'b0010);
  assign w_ref = sdram_cke && (w_cmd == 4'b0001);
  assign w_lmr = sdram_cke && (w_cmd == 4'b0000);

  assign w_gated    = !r_mode_ok && (w_act || w_rd || w_wr || w_bt || w_ref);
  assign w_any_open = (r_bank[0] == B_OPEN) || (r_bank[1] == B_OPEN) ||
                      (r_bank[2] == B_OPEN) || (r_bank[3] == B_OPEN);
  assign w_rw_ok    = (w_rd || w_wr) && r_mode_ok && (r_bank[sdram_ba] == B_OPEN) &&
                      (r_trcd[sdram_ba] == 4'd0);
  // Anything that claims the data bus or closes the bursting bank stops further words.
  assign w_trunc    = w_rw_ok || (w_bt && r_mode_ok) ||
                      (w_pre && (sdram_a[10] || (sdram_ba == r_bst_bank)));
  assign w_unused   = ^sdram_a[12:11];
  assign w_addr     = {w_iss_bank, w_iss_row, w_iss_col};

  function automatic logic [8:0] f_col(input logic [8:0] col, input logic [2:0] k,
                                       input logic [1:0] bl, input logic ilv);
    logic [8:0] mask;
    logic [8:0] low;
    mask = (9'd1 << bl) - 9'd1;
    low  = ilv ? (col ^ {6'd0, k}) : (col + {6'd0, k});
    return (col & ~mask) | (low & mask);
  endfunction

  always_comb begin
    w_new_last = 3'd0;
    case (r_bl)
      2'd0:    w_new_last = 3'd0;
      2'd1:    w_new_last = 3'd1;
      2'd2:    w_new_last = 3'd3;
      default: w_new_last = 3'd7;
    endcase
  end

  always_comb begin
    w_bank_next     = r_bank;
    w_row_next      = r_row;
    w_trcd_next     = r_trcd;
    w_mode_ok_next  = r_mode_ok;
    w_cl3_next      = r_cl3;
    w_bl_next       = r_bl;
    w_ilv_next      = r_ilv;
    w_sw_next       = r_sw;
    w_bst_act_next  = r_bst_act;
    w_bst_wr_next   = r_bst_wr;
    w_bst_ap_next   = r_bst_ap;
    w_bst_bank_next = r_bst_bank;
    w_bst_row_next  = r_bst_row;
    w_bst_col_next  = r_bst_col;
    w_bst_k_next    = r_bst_k;
    w_bst_last_next = r_bst_last;
    w_v1_next       = r_v1;
    w_v2_next       = r_v2;
    w_hold_next     = r_hold;
    w_dq_out_next   = r_dq_out;
    w_dq_oe_next    = r_dq_oe;
    w_err_next      = r_err;
    w_err_code_next = r_err_code;
    w_ref_cnt_next  = r_ref_cnt;
    w_iss_valid     = 1'b0;
    w_iss_wr        = 1'b0;
    w_iss_bank      = 2'd0;
    w_iss_row       = '0;
    w_iss_col       = 9'd0;
    w_err_hit       = 1'b0;
    w_err_val       = 3'd0;

    if (sdram_cke) begin
      for (int b = 0; b < 4; b++) begin
        if (r_trcd[b] != 4'd0) w_trcd_next[b] = r_trcd[b] - 4'd1;
      end

      // RAM output is one stage; CL3 adds a hold stage before the pins.
      w_v1_next = 1'b0;
      if (r_cl3) begin
        w_v2_next    = r_v1;
        w_hold_next  = r_ram_q;
        w_dq_oe_next = r_v2;
        if (r_v2) w_dq_out_next = r_hold;
      end else begin
        w_v2_next    = 1'b0;
        w_dq_oe_next = r_v1;
        if (r_v1) w_dq_out_next = r_ram_q;
      end

      if (r_bst_act) begin
        if (w_trunc) begin
          w_bst_act_next = 1'b0;
        end else begin
          w_iss_valid = 1'b1;
          w_iss_wr    = r_bst_wr;
          w_iss_bank  = r_bst_bank;
          w_iss_row   = r_bst_row;
          w_iss_col   = f_col(r_bst_col, r_bst_k, r_bl, r_ilv);
          if (r_bst_k == r_bst_last) begin
            w_bst_act_next = 1'b0;
            if (r_bst_ap) w_bank_next[r_bst_bank] = B_IDLE;
          end else begin
            w_bst_k_next = r_bst_k + 3'd1;
          end
        end
      end

      if (w_gated) begin
        w_err_hit = 1'b1;
        w_err_val = 3'd1;
      end else if (w_lmr) begin
        if (w_any_open) begin
          w_err_hit = 1'b1;
          w_err_val = 3'd5;
        end else if (!((sdram_a[6:4] == 3'd2) || (sdram_a[6:4] == 3'd3)) || sdram_a[2]) begin
          w_err_hit = 1'b1;
          w_err_val = 3'd6;
        end else begin
          w_cl3_next     = sdram_a[4];
          w_bl_next      = sdram_a[1:0];
          w_ilv_next     = sdram_a[3];
          w_sw_next      = sdram_a[9];
          w_mode_ok_next = 1'b1;
        end
      end else if (w_act) begin
        if (r_bank[sdram_ba] == B_OPEN) begin
          w_err_hit = 1'b1;
          w_err_val = 3'd2;
        end else begin
          w_bank_next[sdram_ba] = B_OPEN;
          w_row_next[sdram_ba]  = sdram_a[RW-1:0];
          w_trcd_next[sdram_ba] = TRCD_LOAD;
        end
      end else if (w_rd || w_wr) begin
        if (r_bank[sdram_ba] == B_IDLE) begin
          w_err_hit = 1'b1;
          w_err_val = 3'd3;
        end else if (r_trcd[sdram_ba] != 4'd0) begin
          w_err_hit = 1'b1;
          w_err_val = 3'd4;
        end else begin
          w_iss_valid = 1'b1;
          w_iss_wr    = w_wr;
          w_iss_bank  = sdram_ba;
          w_iss_row   = r_row[sdram_ba];
          w_iss_col   = sdram_a[8:0];
          if ((w_wr && r_sw) || (w_new_last == 3'd0)) begin
            w_bst_act_next = 1'b0;
            if (sdram_a[10]) w_bank_next[sdram_ba] = B_IDLE;
          end else begin
            w_bst_act_next  = 1'b1;
            w_bst_wr_next   = w_wr;
            w_bst_ap_next   = sdram_a[10];
            w_bst_bank_next = sdram_ba;
            w_bst_row_next  = r_row[sdram_ba];
            w_bst_col_next  = sdram_a[8:0];
            w_bst_k_next    = 3'd1;
            w_bst_last_next = w_new_last;
          end
          // Bus turnaround: pending read data is thrown away when a write takes the bus.
          if (w_wr) begin
            w_v2_next    = 1'b0;
            w_dq_oe_next = 1'b0;
          end
        end
      end else if (w_pre) begin
        if (sdram_a[10]) begin
          for (int b = 0; b < 4; b++) w_bank_next[b] = B_IDLE;
        end else begin
          w_bank_next[sdram_ba] = B_IDLE;
        end
      end else if (w_ref) begin
        if (w_any_open) begin
          w_err_hit = 1'b1;
          w_err_val = 3'd5;
        end else begin
          w_ref_cnt_next = r_ref_cnt + 16'd1;
        end
      end

      if (w_iss_valid && !w_iss_wr) w_v1_next = 1'b1;
      if (w_err_hit && !r_err) begin
        w_err_next      = 1'b1;
        w_err_code_next = w_err_val;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_bank     <= {B_IDLE, B_IDLE, B_IDLE, B_IDLE};
      r_row      <= '0;
      r_trcd     <= '0;
      r_mode_ok  <= 1'b0;
      r_cl3      <= 1'b0;
      r_bl       <= 2'd0;
      r_ilv      <= 1'b0;
      r_sw       <= 1'b0;
      r_bst_act  <= 1'b0;
      r_bst_wr   <= 1'b0;
      r_bst_ap   <= 1'b0;
      r_bst_bank <= 2'd0;
      r_bst_row  <= '0;
      r_bst_col  <= 9'd0;
      r_bst_k    <= 3'd0;
      r_bst_last <= 3'd0;
      r_v1       <= 1'b0;
      r_v2       <= 1'b0;
      r_hold     <= 16'd0;
      r_dq_out   <= 16'd0;
      r_dq_oe    <= 1'b0;
      r_err      <= 1'b0;
      r_err_code <= 3'd0;
      r_ref_cnt  <= 16'd0;
    end else begin
      r_bank     <= w_bank_next;
      r_row      <= w_row_next;
      r_trcd     <= w_trcd_next;
      r_mode_ok  <= w_mode_ok_next;
      r_cl3      <= w_cl3_next;
      r_bl       <= w_bl_next;
      r_ilv      <= w_ilv_next;
      r_sw       <= w_sw_next;
      r_bst_act  <= w_bst_act_next;
      r_bst_wr   <= w_bst_wr_next;
      r_bst_ap   <= w_bst_ap_next;
      r_bst_bank <= w_bst_bank_next;
      r_bst_row  <= w_bst_row_next;
      r_bst_col  <= w_bst_col_next;
      r_bst_k    <= w_bst_k_next;
      r_bst_last <= w_bst_last_next;
      r_v1       <= w_v1_next;
      r_v2       <= w_v2_next;
      r_hold     <= w_hold_next;
      r_dq_out   <= w_dq_out_next;
      r_dq_oe    <= w_dq_oe_next;
      r_err      <= w_err_next;
      r_err_code <= w_err_code_next;
      r_ref_cnt  <= w_ref_cnt_next;
    end
  end

  // Backing store is deliberately not reset so contents survive a harness reset.
  always_ff @(posedge clk) begin
    if (w_iss_valid) begin
      if (w_iss_wr) begin
        if (!sdram_dqml) r_mem_lo[w_addr] <= dq_in[7:0];
        if (!sdram_dqmh) r_mem_hi[w_addr] <= dq_in[15:8];
      end else begin
        r_ram_q <= {r_mem_hi[w_addr], r_mem_lo[w_addr]};
      end
    end
  end

  assign dq_out      = r_dq_out;
  assign dq_oe       = r_dq_oe;
  assign mode_ok     = r_mode_ok;
  assign err         = r_err;
  assign err_code    = r_err_code;
  assign refresh_cnt = r_ref_cnt;

endmodule

// File: tb/tb_sdram_responder.sv
// Directed bench for sdram_responder: expected read beats (cycle + data) are queued when a
// READ is issued and popped whenever the responder drives the bus.
module tb_sdram_responder;
  localparam logic [3:0] C_NOP = 4'b0111;
  localparam logic [3:0] C_ACT = 4'b0011;
  localparam logic [3:0] C_RD  = 4'b0101;
  localparam logic [3:0] C_WR  = 4'b0100;
  localparam logic [3:0] C_BT  = 4'b0110;
  localparam logic [3:0] C_PRE = 4'b0010;
  localparam logic [3:0] C_REF = 4'b0001;
  localparam logic [3:0] C_LMR = 4'b0000;

  logic        clk = 1'b0;
  logic        reset_n, cke, ncs, nras, ncas, nwe, dqml, dqmh;
  logic [1:0]  ba;
  logic [12:0] a;
  logic [15:0] dq_in;
  logic [15:0] dq_out, refresh_cnt;
  logic        dq_oe, mode_ok, err;
  logic [2:0]  err_code;

  typedef struct { int c; logic [15:0] d; } exp_t;
  exp_t q[$];
  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sdram_responder #(.MEM_AW(16), .RCD(3)) dut (
    .clk(clk), .reset_n(reset_n), .sdram_cke(cke),
    .sdram_ncs(ncs), .sdram_nras(nras), .sdram_ncas(ncas), .sdram_nwe(nwe),
    .sdram_ba(ba), .sdram_a(a), .sdram_dqml(dqml), .sdram_dqmh(dqmh),
    .dq_in(dq_in), .dq_out(dq_out), .dq_oe(dq_oe), .mode_ok(mode_ok),
    .err(err), .err_code(err_code), .refresh_cnt(refresh_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
    total++;
    assert (got === expv) else begin
      bad++;
      $error("FAIL %s: got=%0h exp=%0h", tag, got, expv);
    end
  endtask

  task automatic tick();
    exp_t e;
    @(negedge clk);
    if (dq_oe !== 1'b0) begin
      total++;
      assert (q.size() != 0) else begin
        bad++;
        $error("FAIL extra_beat: got dq_out=%h at cyc %0d, exp no beat", dq_out, cyc);
      end
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("beat_cyc", cyc, e.c);
        chk("beat_data", {16'd0, dq_out}, {16'd0, e.d});
      end
    end
    $display("cyc=%0d oe=%b dq_out=%h err=%b code=%0d ref=%0d", cyc, dq_oe, dq_out, err,
             err_code, refresh_cnt);
  endtask

  task automatic cmd(input logic [3:0] c, input logic [1:0] b, input logic [12:0] addr);
    {ncs, nras, ncas, nwe} = c;
    ba = b;
    a  = addr;
    tick();
    {ncs, nras, ncas, nwe} = C_NOP;
  endtask

  task automatic push(input int at, input logic [15:0] d);
    q.push_back('{at, d});
  endtask

  task automatic wr_burst(input logic [1:0] b, input logic [8:0] col, input int n,
                          input logic [15:0] base, input logic [15:0] step, input logic mh);
    dq_in = base;
    dqmh  = mh;
    cmd(C_WR, b, {4'd0, col});
    for (int k = 1; k < n; k++) begin
      dq_in = base + step * 16'(k);
      tick();
    end
    dqmh = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    repeat (2) tick();
    reset_n = 1'b1;
    tick();
  endtask

  initial begin
    int t;
    logic [15:0] pat[4];
    reset_n = 1'b1; cke = 1'b1; {ncs, nras, ncas, nwe} = C_NOP;
    ba = 2'd0; a = 13'd0; dqml = 1'b0; dqmh = 1'b0; dq_in = 16'd0;
    do_reset();
    chk("rst_dq_out", {16'd0, dq_out}, 32'd0);
    chk("rst_dq_oe", {31'd0, dq_oe}, 32'd0);
    chk("rst_mode_ok", {31'd0, mode_ok}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_err_code", {29'd0, err_code}, 32'd0);
    chk("rst_refresh", {16'd0, refresh_cnt}, 32'd0);

    // Command before mode register load
    cmd(C_RD, 2'd0, 13'd0);
    repeat (3) tick();
    chk("premode_err", {31'd0, err}, 32'd1);
    chk("premode_code", {29'd0, err_code}, 32'd1);
    chk("premode_oe", {31'd0, dq_oe}, 32'd0);
    do_reset();
    chk("rst2_err", {31'd0, err}, 32'd0);

    // CL2 BL1 single-write, masked high byte
    cmd(C_LMR, 2'd0, 13'h220);
    chk("lmr_mode_ok", {31'd0, mode_ok}, 32'd1);
    cmd(C_ACT, 2'd1, 13'd5);
    repeat (2) tick();
    wr_burst(2'd1, 9'h10, 1, 16'h1234, 16'h0, 1'b0);
    wr_burst(2'd1, 9'h10, 1, 16'hA55A, 16'h0, 1'b1);
    cmd(C_PRE, 2'd1, 13'd0);
    cmd(C_ACT, 2'd1, 13'd5);
    repeat (2) tick();
    push(cyc + 2, 16'h125A);
    cmd(C_RD, 2'd1, 13'h010);
    repeat (4) tick();
    chk("cl2_drained", q.size(), 32'd0);
    chk("cl2_no_err", {31'd0, err}, 32'd0);

    // CL3 BL4 sequential: write wraps inside the aligned block
    cmd(C_PRE, 2'd0, 13'h400);
    cmd(C_LMR, 2'd0, 13'h032);
    cmd(C_ACT, 2'd0, 13'd2);
    repeat (2) tick();
    wr_burst(2'd0, 9'd6, 4, 16'h1111, 16'h1111, 1'b0);
    t = cyc;
    pat = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
    for (int k = 0; k < 4; k++) push(t + 3 + k, pat[k]);
    cmd(C_RD, 2'd0, 13'd6);
    repeat (6) tick();
    chk("bl4_drained", q.size(), 32'd0);
    chk("bl4_oe_low", {31'd0, dq_oe}, 32'd0);
    t = cyc;
    pat = '{16'h3333, 16'h4444, 16'h1111, 16'h2222};
    for (int k = 0; k < 4; k++) push(t + 3 + k, pat[k]);
    cmd(C_RD, 2'd0, 13'd4);
    repeat (6) tick();
    chk("bl4_col4_drained", q.size(), 32'd0);

    // CL3 BL4 interleaved from column 5 -> 5,4,7,6
    cmd(C_PRE, 2'd0, 13'h400);
    cmd(C_LMR, 2'd0, 13'h03A);
    cmd(C_ACT, 2'd0, 13'd2);
    repeat (2) tick();
    t = cyc;
    pat = '{16'h4444, 16'h3333, 16'h2222, 16'h1111};
    for (int k = 0; k < 4; k++) push(t + 3 + k, pat[k]);
    cmd(C_RD, 2'd0, 13'd5);
    repeat (6) tick();
    chk("ilv_drained", q.size(), 32'd0);

    // CL2 BL8: burst terminate, write-after-read turnaround, wrap from column 3
    cmd(C_PRE, 2'd0, 13'h400);
    cmd(C_LMR, 2'd0, 13'h023);
    cmd(C_ACT, 2'd2, 13'd1);
    repeat (2) tick();
    wr_burst(2'd2, 9'd0, 8, 16'h0100, 16'h0001, 1'b0);
    t = cyc;
    push(t + 2, 16'h0100);
    push(t + 3, 16'h0101);
    cmd(C_RD, 2'd2, 13'd0);
    tick();
    cmd(C_BT, 2'd0, 13'd0);
    repeat (5) tick();
    chk("bt_drained", q.size(), 32'd0);
    chk("bt_oe_low", {31'd0, dq_oe}, 32'd0);
    t = cyc;
    push(t + 2, 16'h0100);
    cmd(C_RD, 2'd2, 13'd0);
    tick();
    wr_burst(2'd2, 9'd0, 8, 16'h0200, 16'h0001, 1'b0);
    chk("turn_drained", q.size(), 32'd0);
    t = cyc;
    for (int k = 0; k < 8; k++) push(t + 2 + k, 16'h0200 + 16'((3 + k) % 8));
    cmd(C_RD, 2'd2, 13'd3);
    repeat (10) tick();
    chk("bl8_drained", q.size(), 32'd0);
    chk("bl8_no_err", {31'd0, err}, 32'd0);

    // Refresh counting, clock-enable hold, refresh with an open bank
    do_reset();
    cmd(C_LMR, 2'd0, 13'h020);
    repeat (3) cmd(C_REF, 2'd0, 13'd0);
    chk("ref_cnt3", {16'd0, refresh_cnt}, 32'd3);
    cke = 1'b0;
    cmd(C_REF, 2'd0, 13'd0);
    cke = 1'b1;
    tick();
    chk("ref_cke_hold", {16'd0, refresh_cnt}, 32'd3);
    chk("ref_no_err", {31'd0, err}, 32'd0);
    cmd(C_ACT, 2'd0, 13'd0);
    cmd(C_REF, 2'd0, 13'd0);
    tick();
    chk("ref_open_code", {29'd0, err_code}, 32'd5);
    chk("ref_open_cnt", {16'd0, refresh_cnt}, 32'd3);

    // tRCD violation, then a second error must not replace the code
    do_reset();
    cmd(C_LMR, 2'd0, 13'h020);
    cmd(C_ACT, 2'd3, 13'd1);
    cmd(C_RD, 2'd3, 13'd0);
    tick();
    chk("trcd_code", {29'd0, err_code}, 32'd4);
    cmd(C_ACT, 2'd3, 13'd1);
    repeat (3) tick();
    chk("trcd_code_sticky", {29'd0, err_code}, 32'd4);
    chk("trcd_err", {31'd0, err}, 32'd1);

    // Illegal CAS latency; read of an idle bank
    do_reset();
    cmd(C_LMR, 2'd0, 13'h010);
    tick();
    chk("badcl_code", {29'd0, err_code}, 32'd6);
    chk("badcl_mode_ok", {31'd0, mode_ok}, 32'd0);
    do_reset();
    cmd(C_LMR, 2'd0, 13'h020);
    cmd(C_RD, 2'd1, 13'd0);
    repeat (3) tick();
    chk("idle_rd_code", {29'd0, err_code}, 32'd3);
    chk("final_drained", q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
